alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares the single-cycle ALU between two requesters: req0 is the core
//   execute path, req1 is the address-gen/CSR helper. Each requester has a
//   valid/ready channel. One registered response channel returns the result
//   tagged with the requester id. At most one operation is outstanding.
//   Sits between the requesters and the ALU; the ALU stays purely combinational.
// PARAMETERS
//   DATA_W   32  operand/result width (must match ALU width)
//   OP_W     4   ALU control width (core_pkg ALU_* encodings, passed through)
//   RR_EN    1   1 = round-robin arbitration; 0 = fixed priority, req0 wins
// PORTS
//   clk             in   1        clock, rising edge
//   rst             in   1        asynchronous, active-high reset
//   req_valid       in   2        per-requester op valid
//   req_ready       out  2        per-requester accept (combinational)
//   req_op          in   2*OP_W   per-requester ALU control; [OP_W-1:0] = req0
//   req_src1        in   2*DATA_W per-requester operand 1
//   req_src2        in   2*DATA_W per-requester operand 2
//   alu_control     out  OP_W     to ALU: op of granted requester, else 0
//   alu_src1        out  DATA_W   to ALU: operand 1 of granted requester, else 0
//   alu_src2        out  DATA_W   to ALU: operand 2 of granted requester, else 0
//   alu_result      in   DATA_W   from ALU
//   alu_zero        in   1        from ALU
//   alu_last_bit    in   1        from ALU
//   rsp_valid       out  1        response valid
//   rsp_ready       in   1        response consumer ready
//   rsp_id          out  1        requester that issued the op
//   rsp_result      out  DATA_W   registered ALU result
//   rsp_zero        out  1        registered zero flag
//   rsp_last_bit    out  1        registered last_bit flag
// BEHAVIOUR
//   - Reset:
//     - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_last_bit=0.
//     - rr_ptr=0 (req0 has priority first). FSM=IDLE.
//     - req_ready=0 while rst is high.
//   - FSM states:
//     - IDLE: no response is held.
//     - HOLD: response is held, rsp_valid=1.
//   - can_issue = (state==IDLE) | (state==HOLD & rsp_ready). Back-to-back issue
//     in the same cycle a held response drains is allowed.
//   - Grant (combinational), only when can_issue:
//     - One valid requester: that requester is granted.
//     - Both valid: RR_EN=1 grants the requester selected by rr_ptr; RR_EN=0 grants req0.
//     - At most one grant bit is set. req_ready = grant.
//   - ALU drive: mux of the granted requester's op and operands. When there is no
//     grant, drive zeros (alu_control=0).
//   - Accept (req_valid[i] & req_ready[i]) latches alu_result, alu_zero,
//     alu_last_bit and id=i into the response register. Next state is HOLD.
//   - Latency: accept at cycle N gives rsp_valid=1 at cycle N+1.
//   - HOLD:
//     - Response fields stay stable until rsp_valid & rsp_ready.
//     - Drain with no new accept: next state is IDLE, rsp_valid=0, data fields
//       keep their last value.
//     - Drain with a new accept: stay in HOLD with the new response.
//   - rr_ptr updates only on accept: rr_ptr <= ~granted_id. Requests alone never
//     move it. With RR_EN=0 it is held at 0.
//   - A requester may deassert req_valid before it is accepted. It is then never
//     granted in that cycle. No state change.
//   - Reset asserted mid-HOLD: the held response is discarded. Outputs return to
//     reset values asynchronously.
//   - Starvation bound (RR_EN=1): a continuously valid requester is accepted
//     within 2 accepts.
// TESTING
//   1. Reset, then req0 valid with op=ALU_ADD, 5+7 -> req_ready[0]=1 in the same
//      cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
//   2. Both valid every cycle, rsp_ready=1, RR_EN=1 -> accepts alternate
//      0,1,0,1; one response per cycle; no idle cycles.
//   3. Hold rsp_ready=0 for 4 cycles with req1 valid -> req_ready=0 and the
//      response is stable for 4 cycles; on the cycle rsp_ready=1, req1 is
//      accepted; its result appears on the next cycle.
//   4. ALU_SUB with 9-9 -> rsp_result=0, rsp_zero=1. ALU_SRA with 0x80000000 by 4
//      -> rsp_result=0xF8000000, rsp_last_bit=0.
//   5. rst pulsed while rsp_valid=1 -> rsp_valid=0 immediately; the next grant
//      with both requesters valid goes to req0.
//   6. RR_EN=0 with both valid for 3 accepts -> all three go to req0; req1 is
//      accepted only after req0 deasserts.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the requester, ALU and response channels around the shared ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*OP_W-1:0]   req_op;
    logic [2*DATA_W-1:0] req_src1;
    logic [2*DATA_W-1:0] req_src2;

    logic [OP_W-1:0]     alu_control;
    logic [DATA_W-1:0]   alu_src1;
    logic [DATA_W-1:0]   alu_src2;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                alu_last_bit;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_zero;
    logic                rsp_last_bit;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2,
        input  alu_result, alu_zero, alu_last_bit,
        input  rsp_ready,
        output req_ready,
        output alu_control, alu_src1, alu_src2,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_last_bit
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2,
        output alu_result, alu_zero, alu_last_bit,
        output rsp_ready,
        input  req_ready,
        input  alu_control, alu_src1, alu_src2,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_last_bit
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one combinational ALU and returns a single
// registered, id-tagged response; at most one operation is outstanding.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              rrPtr_q, rrPtr_d;
    logic              rspId_q, rspId_d;
    logic [DATA_W-1:0] rspResult_q, rspResult_d;
    logic              rspZero_q, rspZero_d;
    logic              rspLastBit_q, rspLastBit_d;

    logic              canIssue;
    logic [1:0]        grant;
    logic              accept;
    logic              grantId;

    // A held response that drains this cycle frees the slot for a same-cycle issue.
    always_comb begin
        canIssue = 1'b0;
        grant    = 2'b00;
        if (!rst) begin
            canIssue = (state_q == IDLE) || bus.rsp_ready;
        end
        if (canIssue) begin
            if (bus.req_valid == 2'b11) begin
                grant = (RR_EN && rrPtr_q) ? 2'b10 : 2'b01;
            end else begin
                grant = bus.req_valid;
            end
        end
    end

    assign accept        = |grant;
    assign grantId       = grant[1];
    assign bus.req_ready = grant;

    always_comb begin
        bus.alu_control = '0;
        bus.alu_src1    = '0;
        bus.alu_src2    = '0;
        if (grant[0]) begin
            bus.alu_control = bus.req_op[OP_W-1:0];
            bus.alu_src1    = bus.req_src1[DATA_W-1:0];
            bus.alu_src2    = bus.req_src2[DATA_W-1:0];
        end else if (grant[1]) begin
            bus.alu_control = bus.req_op[2*OP_W-1:OP_W];
            bus.alu_src1    = bus.req_src1[2*DATA_W-1:DATA_W];
            bus.alu_src2    = bus.req_src2[2*DATA_W-1:DATA_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        rrPtr_d      = rrPtr_q;
        rspId_d      = rspId_q;
        rspResult_d  = rspResult_q;
        rspZero_d    = rspZero_q;
        rspLastBit_d = rspLastBit_q;
        if (accept) begin
            state_d      = HOLD;
            rspId_d      = grantId;
            rspResult_d  = bus.alu_result;
            rspZero_d    = bus.alu_zero;
            rspLastBit_d = bus.alu_last_bit;
            rrPtr_d      = RR_EN ? ~grantId : 1'b0;
        end else if ((state_q == HOLD) && bus.rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rrPtr_q      <= 1'b0;
            rspId_q      <= 1'b0;
            rspResult_q  <= '0;
            rspZero_q    <= 1'b0;
            rspLastBit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rrPtr_q      <= rrPtr_d;
            rspId_q      <= rspId_d;
            rspResult_q  <= rspResult_d;
            rspZero_q    <= rspZero_d;
            rspLastBit_q <= rspLastBit_d;
        end
    end

    assign bus.rsp_valid    = (state_q == HOLD);
    assign bus.rsp_id       = rspId_q;
    assign bus.rsp_result   = rspResult_q;
    assign bus.rsp_zero     = rspZero_q;
    assign bus.rsp_last_bit = rspLastBit_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin and a fixed-priority instance, each
// behind a small ALU model, driven from vector tables with a response scoreboard.
module tb_alu_share_arbiter;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) busA ();
    alu_share_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) busB ();

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .RR_EN(1'b1)) dutRr (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .RR_EN(1'b0)) dutFixed (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    assign busA.alu_result   = aluModel(busA.alu_control, busA.alu_src1, busA.alu_src2);
    assign busA.alu_zero     = (busA.alu_result == 32'd0);
    assign busA.alu_last_bit = busA.alu_result[0];
    assign busB.alu_result   = aluModel(busB.alu_control, busB.alu_src1, busB.alu_src2);
    assign busB.alu_zero     = (busB.alu_result == 32'd0);
    assign busB.alu_last_bit = busB.alu_result[0];

    typedef struct {
        logic [1:0]  valid;
        logic        rspReady;
        logic [3:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [1:0]  expReady;
        logic [31:0] expResult;
        logic        expZero;
        logic        expLast;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        zero;
        logic        last;
    } rsp_t;

    rsp_t expQ[$];
    rsp_t curExp;
    bit   expValid     = 1'b0;
    bit   lastAccept   = 1'b0;
    bit   lastRspReady = 1'b0;
    int   checkCount   = 0;
    int   errorCount   = 0;

    vec_t tableA[15];
    vec_t tableB[6];

    function automatic vec_t mkVec(input logic [1:0] valid, input logic rdy,
                                   input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                   input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                   input logic [1:0] er, input logic [31:0] res,
                                   input logic z, input logic l);
        vec_t v;
        v.valid = valid;  v.rspReady = rdy;
        v.op0 = op0;      v.a0 = a0;        v.b0 = b0;
        v.op1 = op1;      v.a1 = a1;        v.b1 = b1;
        v.expReady = er;  v.expResult = res;
        v.expZero = z;    v.expLast = l;
        return v;
    endfunction

    function automatic vec_t idleVec(input logic rdy);
        return mkVec(2'b00, rdy, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0, 2'b00, 32'd0, 1'b0, 1'b0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input vec_t v);
        if (sel == 0) begin
            busA.req_valid = v.valid;
            busA.rsp_ready = v.rspReady;
            busA.req_op    = {v.op1, v.op0};
            busA.req_src1  = {v.a1, v.a0};
            busA.req_src2  = {v.b1, v.b0};
        end else begin
            busB.req_valid = v.valid;
            busB.rsp_ready = v.rspReady;
            busB.req_op    = {v.op1, v.op0};
            busB.req_src1  = {v.a1, v.a0};
            busB.req_src2  = {v.b1, v.b0};
        end
    endtask

    task automatic sampleOut(input int sel, output rsp_t r, output logic rv, output logic [1:0] rdy,
                             output logic [3:0] ctl, output logic [31:0] s1, output logic [31:0] s2);
        if (sel == 0) begin
            r.id = busA.rsp_id;  r.result = busA.rsp_result;
            r.zero = busA.rsp_zero;  r.last = busA.rsp_last_bit;
            rv = busA.rsp_valid;  rdy = busA.req_ready;
            ctl = busA.alu_control;  s1 = busA.alu_src1;  s2 = busA.alu_src2;
        end else begin
            r.id = busB.rsp_id;  r.result = busB.rsp_result;
            r.zero = busB.rsp_zero;  r.last = busB.rsp_last_bit;
            rv = busB.rsp_valid;  rdy = busB.req_ready;
            ctl = busB.alu_control;  s1 = busB.alu_src1;  s2 = busB.alu_src2;
        end
    endtask

    // One clock of stimulus: check the registered response, drive new requests, check grant and ALU drive.
    task automatic step(input int sel, input string name, input vec_t v);
        rsp_t        r;
        logic        rv;
        logic [1:0]  rdy;
        logic [3:0]  ctl, eCtl;
        logic [31:0] s1, s2, eS1, eS2;
        @(posedge clk);
        #1;
        if (lastAccept) begin
            curExp   = expQ.pop_front();
            expValid = 1'b1;
        end else if (expValid && lastRspReady) begin
            expValid = 1'b0;
        end
        sampleOut(sel, r, rv, rdy, ctl, s1, s2);
        checkOutput($sformatf("%s.rsp_valid", name), 32'(rv), 32'(expValid));
        if (expValid) begin
            checkOutput($sformatf("%s.rsp_id", name), 32'(r.id), 32'(curExp.id));
            checkOutput($sformatf("%s.rsp_result", name), r.result, curExp.result);
            checkOutput($sformatf("%s.rsp_zero", name), 32'(r.zero), 32'(curExp.zero));
            checkOutput($sformatf("%s.rsp_last_bit", name), 32'(r.last), 32'(curExp.last));
        end
        applyStimulus(sel, v);
        #1;
        sampleOut(sel, r, rv, rdy, ctl, s1, s2);
        checkOutput($sformatf("%s.req_ready", name), 32'(rdy), 32'(v.expReady));
        eCtl = 4'd0;  eS1 = 32'd0;  eS2 = 32'd0;
        if (v.expReady[0]) begin
            eCtl = v.op0;  eS1 = v.a0;  eS2 = v.b0;
        end else if (v.expReady[1]) begin
            eCtl = v.op1;  eS1 = v.a1;  eS2 = v.b1;
        end
        checkOutput($sformatf("%s.alu_control", name), 32'(ctl), 32'(eCtl));
        checkOutput($sformatf("%s.alu_src1", name), s1, eS1);
        checkOutput($sformatf("%s.alu_src2", name), s2, eS2);
        if (v.expReady != 2'b00) begin
            expQ.push_back('{id: v.expReady[1], result: v.expResult, zero: v.expZero, last: v.expLast});
        end
        lastAccept   = (v.expReady != 2'b00);
        lastRspReady = v.rspReady;
    endtask

    initial begin
        rsp_t        r;
        logic        rv;
        logic [1:0]  rdy;
        logic [3:0]  ctl;
        logic [31:0] s1, s2;

        tableA[0]  = mkVec(2'b01, 1'b1, ALU_ADD, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0,
                           2'b01, 32'd12, 1'b0, 1'b0);
        tableA[1]  = mkVec(2'b11, 1'b1, ALU_ADD, 32'd1, 32'd1, ALU_SUB, 32'd10, 32'd3,
                           2'b10, 32'd7, 1'b0, 1'b1);
        tableA[2]  = mkVec(2'b11, 1'b1, ALU_XOR, 32'hFF, 32'h0F, ALU_ADD, 32'd2, 32'd2,
                           2'b01, 32'hF0, 1'b0, 1'b0);
        tableA[3]  = mkVec(2'b11, 1'b1, ALU_ADD, 32'd3, 32'd3, ALU_OR, 32'h100, 32'h1,
                           2'b10, 32'h101, 1'b0, 1'b1);
        tableA[4]  = mkVec(2'b01, 1'b1, ALU_SUB, 32'd9, 32'd9, ALU_ADD, 32'd0, 32'd0,
                           2'b01, 32'd0, 1'b1, 1'b0);
        tableA[5]  = mkVec(2'b10, 1'b1, ALU_ADD, 32'd0, 32'd0, ALU_SRA, 32'h8000_0000, 32'd4,
                           2'b10, 32'hF800_0000, 1'b0, 1'b0);
        tableA[6]  = idleVec(1'b1);
        tableA[7]  = idleVec(1'b0);
        tableA[8]  = mkVec(2'b01, 1'b0, ALU_AND, 32'hF0F0, 32'hFF00, ALU_ADD, 32'd0, 32'd0,
                           2'b01, 32'hF000, 1'b0, 1'b0);
        for (int i = 9; i < 13; i++) begin
            tableA[i] = mkVec(2'b10, 1'b0, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd100, 32'd23,
                              2'b00, 32'd0, 1'b0, 1'b0);
        end
        tableA[13] = mkVec(2'b10, 1'b1, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd100, 32'd23,
                           2'b10, 32'd123, 1'b0, 1'b1);
        tableA[14] = idleVec(1'b1);

        tableB[0] = mkVec(2'b11, 1'b1, ALU_ADD, 32'd1, 32'd1, ALU_ADD, 32'd50, 32'd50,
                          2'b01, 32'd2, 1'b0, 1'b0);
        tableB[1] = mkVec(2'b11, 1'b1, ALU_ADD, 32'd2, 32'd1, ALU_ADD, 32'd50, 32'd50,
                          2'b01, 32'd3, 1'b0, 1'b1);
        tableB[2] = mkVec(2'b11, 1'b1, ALU_ADD, 32'd2, 32'd2, ALU_ADD, 32'd50, 32'd50,
                          2'b01, 32'd4, 1'b0, 1'b0);
        tableB[3] = mkVec(2'b10, 1'b1, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd50, 32'd50,
                          2'b10, 32'd100, 1'b0, 1'b0);
        tableB[4] = idleVec(1'b1);
        tableB[5] = idleVec(1'b1);

        // Reset state, with requests already valid to show they are not granted during reset.
        applyStimulus(0, tableA[1]);
        applyStimulus(1, tableB[0]);
        #2 rst = 1'b1;
        #1;
        sampleOut(0, r, rv, rdy, ctl, s1, s2);
        checkOutput("reset.rsp_valid", 32'(rv), 32'd0);
        checkOutput("reset.rsp_id", 32'(r.id), 32'd0);
        checkOutput("reset.rsp_result", r.result, 32'd0);
        checkOutput("reset.rsp_zero", 32'(r.zero), 32'd0);
        checkOutput("reset.rsp_last_bit", 32'(r.last), 32'd0);
        checkOutput("reset.req_ready", 32'(rdy), 32'd0);
        checkOutput("reset.alu_control", 32'(ctl), 32'd0);
        sampleOut(1, r, rv, rdy, ctl, s1, s2);
        checkOutput("resetB.rsp_valid", 32'(rv), 32'd0);
        checkOutput("resetB.req_ready", 32'(rdy), 32'd0);
        applyStimulus(0, idleVec(1'b0));
        applyStimulus(1, idleVec(1'b0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(0, $sformatf("vecA%0d", i), tableA[i]);
        end

        // Reset in the middle of a held response; the pointer had moved to req1 beforehand.
        step(0, "rstFill", mkVec(2'b01, 1'b0, ALU_ADD, 32'd1, 32'd2, ALU_ADD, 32'd0, 32'd0,
                                 2'b01, 32'd3, 1'b0, 1'b1));
        step(0, "rstHold", idleVec(1'b0));
        #1;
        rst = 1'b1;
        applyStimulus(0, mkVec(2'b11, 1'b1, ALU_ADD, 32'd4, 32'd4, ALU_SUB, 32'd1, 32'd1,
                               2'b00, 32'd0, 1'b0, 1'b0));
        #1;
        sampleOut(0, r, rv, rdy, ctl, s1, s2);
        checkOutput("midReset.rsp_valid", 32'(rv), 32'd0);
        checkOutput("midReset.rsp_result", r.result, 32'd0);
        checkOutput("midReset.rsp_last_bit", 32'(r.last), 32'd0);
        checkOutput("midReset.req_ready", 32'(rdy), 32'd0);
        expQ.delete();
        expValid   = 1'b0;
        lastAccept = 1'b0;
        applyStimulus(0, idleVec(1'b0));
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, "postReset", mkVec(2'b11, 1'b1, ALU_ADD, 32'd4, 32'd4, ALU_SUB, 32'd1, 32'd1,
                                   2'b01, 32'd8, 1'b0, 1'b0));
        step(0, "postResetRsp", idleVec(1'b1));
        step(0, "postResetDrain", idleVec(1'b1));

        // Fixed priority: req0 wins every contested cycle, req1 only gets in once req0 drops.
        for (int i = 0; i < 6; i++) begin
            step(1, $sformatf("vecB%0d", i), tableB[i]);
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
